// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous (1-cycle latency) ROM.
// Issues word addresses, captures the returned word one edge later, and holds
// fetched {pc, instr} pairs in a 2-entry queue handed to decode over valid/ready.
// A redirect flushes the queue and any in-flight fetch and restarts at the new pc.
module fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          ADDRESS_WIDTH = 16,
    parameter int          DATA_WIDTH    = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic [ADDRESS_WIDTH-3:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_q,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [DATA_WIDTH-1:0]    out_instr
);

    logic [31:0]           fetch_pc;
    logic                  inflight;
    logic [31:0]           inflight_pc;

    logic [31:0]           q_pc    [2];
    logic [DATA_WIDTH-1:0] q_instr [2];
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic [1:0]            count;

    logic                  pop;
    logic                  push;
    logic                  issue;
    logic [2:0]            credit_used;

    // The two low redirect bits are discarded: fetch is always word aligned.
    logic                  unused_redirect_bits;
    assign unused_redirect_bits = ^redirect_pc[1:0];

    // ROM address follows fetch_pc directly; upper pc bits beyond the ROM are ignored.
    assign rom_addr = fetch_pc[ADDRESS_WIDTH-1:2];

    // Handshake and credit decode; redirect suppresses every queue/issue action.
    always_comb begin
        out_valid   = (count != 2'd0) && !redirect_valid;
        pop         = out_valid && out_ready;
        push        = inflight && !redirect_valid;
        // Entries held plus the one returning from the ROM, minus the one leaving.
        credit_used = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
        issue       = !redirect_valid && (credit_used < 3'd2);
        out_pc      = q_pc[rd_ptr];
        out_instr   = q_instr[rd_ptr];
    end

    // Fetch pointer and the single in-flight ROM request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
        end else if (redirect_valid) begin
            fetch_pc    <= {redirect_pc[31:2], 2'b00};
            inflight    <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= fetch_pc;
            fetch_pc    <= fetch_pc + 32'd4;
        end else begin
            inflight    <= 1'b0;
        end
    end

    // Output queue: push the returning ROM word, pop on handshake, flush on redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_pc[0]    <= 32'd0;
            q_pc[1]    <= 32'd0;
            q_instr[0] <= '0;
            q_instr[1] <= '0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else if (redirect_valid) begin
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            count      <= 2'd0;
        end else begin
            if (push) begin
                q_pc[wr_ptr]    <= inflight_pc;
                q_instr[wr_ptr] <= rom_q;
                wr_ptr          <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural synchronous ROM holding ROM[i]=i.
module tb_fetch_unit;

    localparam int AW = 16;
    localparam int DW = 32;

    logic          clk;
    logic          rst_n;
    logic [AW-3:0] rom_addr;
    logic [DW-1:0] rom_q;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_pc;
    logic [DW-1:0] out_instr;

    int checks;
    int errors;

    fetch_unit #(
        .RESET_PC      (32'h0000_0000),
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rom_addr       (rom_addr),
        .rom_q          (rom_q),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    // Clock: rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous ROM, one cycle read latency, word i holds value i.
    always @(posedge clk) rom_q <= {{(DW-AW+2){1'b0}}, rom_addr};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input logic exp_valid,
                           input logic [31:0] exp_pc, input logic [31:0] exp_instr);
        checks++;
        if (out_valid !== exp_valid) begin
            errors++;
            $display("FAIL %s: out_valid got %0b expected %0b", name, out_valid, exp_valid);
        end
        if (exp_valid) begin
            checks++;
            if (out_pc !== exp_pc || out_instr !== exp_instr) begin
                errors++;
                $display("FAIL %s: pc/instr got %h/%h expected %h/%h",
                         name, out_pc, out_instr, exp_pc, exp_instr);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
        #22;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || rom_addr !== 14'd0) begin
            errors++;
            $display("FAIL reset_state: valid/pc/instr/addr got %b/%h/%h/%h expected 0/0/0/0",
                     out_valid, out_pc, out_instr, rom_addr);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_stream();
        tick();
        chk_out("stream_edge1", 1'b0, 32'd0, 32'd0);
        tick();
        chk_out("stream_edge2", 1'b1, 32'd0, 32'd0);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_out("stream_seq", 1'b1, 32'(4 * i), 32'(i));
        end
    endtask

    // Head is pc 28; queue fills to 2 and issue stops while decode stalls.
    task automatic test_stall();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("stall_hold", 1'b1, 32'd28, 32'd7);
            checks++;
            if (rom_addr !== 14'd9) begin
                errors++;
                $display("FAIL stall_no_issue: rom_addr got %h expected %h", rom_addr, 14'd9);
            end
        end
        out_ready = 1'b1;
        tick();
        chk_out("stall_resume0", 1'b1, 32'd32, 32'd8);
        tick();
        chk_out("stall_resume1", 1'b1, 32'd36, 32'd9);
        tick();
        chk_out("stall_resume2", 1'b1, 32'd40, 32'd10);
    endtask

    // Redirect to 0x40 while two entries are queued.
    task automatic test_redirect_full();
        out_ready = 1'b0;
        tick();
        chk_out("redir_prefill", 1'b1, 32'd40, 32'd10);
        redirect_valid = 1'b1; redirect_pc = 32'h40; out_ready = 1'b1;
        #1;
        chk_out("redir_cycle_low", 1'b0, 32'd0, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk_out("redir_flushed", 1'b0, 32'd0, 32'd0);
        checks++;
        if (rom_addr !== 14'h10) begin
            errors++;
            $display("FAIL redir_rom_addr: got %h expected %h", rom_addr, 14'h10);
        end
        tick();
        chk_out("redir_edge1", 1'b0, 32'd0, 32'd0);
        tick();
        chk_out("redir_first", 1'b1, 32'h40, 32'd16);
        tick();
        chk_out("redir_second", 1'b1, 32'h44, 32'd17);
    endtask

    // Unaligned redirect in steady state with decode ready: no handshake that cycle.
    task automatic test_redirect_unaligned();
        redirect_valid = 1'b1; redirect_pc = 32'h43; out_ready = 1'b1;
        #1;
        chk_out("unal_cycle_low", 1'b0, 32'd0, 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk_out("unal_flushed", 1'b0, 32'd0, 32'd0);
        checks++;
        if (rom_addr !== 14'h10) begin
            errors++;
            $display("FAIL unal_rom_addr: got %h expected %h", rom_addr, 14'h10);
        end
        tick();
        tick();
        chk_out("unal_first", 1'b1, 32'h40, 32'd16);
        tick();
        chk_out("unal_second", 1'b1, 32'h44, 32'd17);
    endtask

    // Last ROM word then crossing into pc 0x1_0000, ROM address wraps to 0.
    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_FFFC;
        tick();
        redirect_valid = 1'b0;
        tick();
        checks++;
        if (rom_addr !== 14'h0) begin
            errors++;
            $display("FAIL wrap_rom_addr: got %h expected %h", rom_addr, 14'h0);
        end
        tick();
        chk_out("wrap_last", 1'b1, 32'h0000_FFFC, 32'h3FFF);
        tick();
        chk_out("wrap_next", 1'b1, 32'h0001_0000, 32'h0);
        tick();
        chk_out("wrap_after", 1'b1, 32'h0001_0004, 32'h1);
    endtask

    // Asynchronous reset mid-cycle while the queue is full.
    task automatic test_async_reset();
        out_ready = 1'b0;
        tick();
        tick();
        chk_out("areset_full", 1'b1, 32'h0001_0004, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_pc !== 32'd0 || out_instr !== 32'd0 || rom_addr !== 14'd0) begin
            errors++;
            $display("FAIL areset_immediate: valid/pc/instr/addr got %b/%h/%h/%h expected 0/0/0/0",
                     out_valid, out_pc, out_instr, rom_addr);
        end
        out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("areset_edge1", 1'b0, 32'd0, 32'd0);
        tick();
        chk_out("areset_first", 1'b1, 32'd0, 32'd0);
        tick();
        chk_out("areset_second", 1'b1, 32'd4, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_unaligned();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
